// File: rtl/enc_dec_pkg.sv
// Shared definitions for the EncDec SECDED link (encoder and decoder).
//
// Contents:
//   - mode encodings as carried on the mode/out_mode buses
//   - code_size_e: the three supported code sizes
//   - per-size data width (4/11/26), parity count (3/4/5), codeword width (8/16/32)
//   - h_col(): H-matrix column for data bit k. Columns are the integers from 3
//     upward that are not powers of two (3,5,6,7,9,...). Powers of two are
//     reserved for the parity bits themselves, so a single-bit error syndrome
//     points straight at the flipped position.
package enc_dec_pkg;

  localparam int AMBA_WORD_W = 32;
  localparam int MAX_DATA_W  = 26;
  localparam int MAX_PAR_W   = 5;

  localparam logic [1:0] MODE_SMALL  = 2'b00;
  localparam logic [1:0] MODE_MEDIUM = 2'b01;
  localparam logic [1:0] MODE_LARGE  = 2'b10;

  typedef enum logic [1:0] {
    CODE_SMALL  = 2'd0,
    CODE_MEDIUM = 2'd1,
    CODE_LARGE  = 2'd2
  } code_size_e;

  // Mode 2'b11 is not a distinct size; it is coded exactly like Large.
  function automatic code_size_e mode_to_size(input logic [1:0] mode);
    code_size_e s;
    case (mode)
      MODE_SMALL:  s = CODE_SMALL;
      MODE_MEDIUM: s = CODE_MEDIUM;
      default:     s = CODE_LARGE;
    endcase
    return s;
  endfunction

  function automatic int data_w(input code_size_e s);
    int w;
    case (s)
      CODE_SMALL:  w = 4;
      CODE_MEDIUM: w = 11;
      default:     w = 26;
    endcase
    return w;
  endfunction

  function automatic int par_w(input code_size_e s);
    int w;
    case (s)
      CODE_SMALL:  w = 3;
      CODE_MEDIUM: w = 4;
      default:     w = 5;
    endcase
    return w;
  endfunction

  function automatic int cw_w(input code_size_e s);
    int w;
    case (s)
      CODE_SMALL:  w = 8;
      CODE_MEDIUM: w = 16;
      default:     w = 32;
    endcase
    return w;
  endfunction

  // H-matrix column table for data bit k (k in 0..25).
  function automatic logic [MAX_PAR_W-1:0] h_col(input int k);
    logic [MAX_PAR_W-1:0] r;
    int idx;
    r   = '0;
    idx = 0;
    for (int c = 3; c < 32; c++) begin
      if ((c & (c - 1)) != 0) begin
        if (idx == k) r = c[MAX_PAR_W-1:0];
        idx++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational extended-Hamming codeword builder.
//
// Ports:
//   data_i  in  26  payload, LSB-aligned; bits above the mode's data width ignored
//   mode_i  in  2   code mode (00 Small, 01 Medium, 10/11 Large)
//   cw_o    out 32  codeword, LSB-aligned, unused upper bits 0
//
// Layout with n parity bits: cw[n-1:0] = P, cw[n] = overall parity,
// cw[cw_w-1:n+1] = data. The decoder's syndrome check reuses this block.
module hamming_parity_gen
  import enc_dec_pkg::*;
(
  input  logic [MAX_DATA_W-1:0]  data_i,
  input  logic [1:0]             mode_i,
  output logic [AMBA_WORD_W-1:0] cw_o
);

  code_size_e             size;
  logic [MAX_DATA_W-1:0]  data_m;
  logic [MAX_PAR_W-1:0]   par;
  logic                   pov;

  always_comb begin
    size   = mode_to_size(mode_i);
    data_m = '0;
    for (int k = 0; k < MAX_DATA_W; k++) begin
      if (k < data_w(size)) data_m[k] = data_i[k];
    end

    // Each set data bit contributes its H column to the parity vector.
    // Columns of the smaller codes never reach the upper parity bits, so
    // those bits stay 0 without extra masking.
    par = '0;
    for (int k = 0; k < MAX_DATA_W; k++) begin
      if (data_m[k]) par = par ^ h_col(k);
    end

    pov = ^{data_m, par};

    cw_o = '0;
    case (size)
      CODE_SMALL:  cw_o[7:0]  = {data_m[3:0], pov, par[2:0]};
      CODE_MEDIUM: cw_o[15:0] = {data_m[10:0], pov, par[3:0]};
      default:     cw_o       = {data_m, pov, par};
    endcase
  end

endmodule

// File: rtl/hamming_enc_pipe.sv
// Two-stage SECDED encoder pipeline between the APB register file and the
// channel/decoder.
//
// Ports:
//   clk        in   1          clock
//   rst        in   1          asynchronous active-low reset
//   clr        in   1          synchronous flush: empties both stages, clears counter
//   mode       in   2          code mode, sampled with data_in
//   data_in    in   AMBA_WORD  payload, LSB-aligned
//   in_valid   in   1          data_in/mode valid
//   in_ready   out  1          block accepts this cycle
//   enc_out    out  AMBA_WORD  codeword, LSB-aligned
//   out_mode   out  2          mode of the word on enc_out (11 reported as received)
//   out_valid  out  1          enc_out valid
//   out_ready  in   1          downstream accepts
//   enc_count  out  CNT_W      words delivered, wraps
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// valid is raised, the payload is held stable until that transfer. Stage 1
// holds the raw word; the parity is computed between stage 1 and stage 2.
// Each stage advances whenever the stage after it is empty or draining, so a
// full pipe can accept and deliver on the same edge without a bubble.
module hamming_enc_pipe
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [AMBA_WORD-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AMBA_WORD-1:0] enc_out,
  output logic [1:0]           out_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     enc_count
);

  logic                  s1_v_q, s1_v_d;
  logic [MAX_DATA_W-1:0] s1_data_q, s1_data_d;
  logic [1:0]            s1_mode_q, s1_mode_d;
  logic                  out_valid_q, out_valid_d;
  logic [AMBA_WORD-1:0]  enc_out_q, enc_out_d;
  logic [1:0]            out_mode_q, out_mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  adv1, adv2;
  logic [AMBA_WORD-1:0]  cw;
  logic                  unused_data_hi;

  // Payload bits above the largest data width never reach the codeword.
  assign unused_data_hi = ^data_in[AMBA_WORD-1:MAX_DATA_W];

  hamming_parity_gen u_parity_gen (
    .data_i (s1_data_q),
    .mode_i (s1_mode_q),
    .cw_o   (cw)
  );

  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_v_q || adv2;
  // Held low while reset is asserted even though the empty pipe could accept.
  assign in_ready = adv1 && rst;

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_data_d   = s1_data_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    enc_out_d   = enc_out_q;
    out_mode_d  = out_mode_q;
    cnt_d       = cnt_q;

    if (clr) begin
      // Flush wins over any accept or advance in the same cycle.
      s1_v_d      = 1'b0;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      if (out_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);

      if (adv2) begin
        out_valid_d = s1_v_q;
        if (s1_v_q) begin
          enc_out_d  = cw;
          out_mode_d = s1_mode_q;
        end
      end

      if (adv1) begin
        s1_v_d = in_valid;
        if (in_valid) begin
          s1_data_d = data_in[MAX_DATA_W-1:0];
          s1_mode_d = mode;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      enc_out_q   <= '0;
      out_mode_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      enc_out_q   <= enc_out_d;
      out_mode_q  <= out_mode_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign enc_out   = enc_out_q;
  assign out_mode  = out_mode_q;
  assign enc_count = cnt_q;

endmodule

// File: tb/tb_hamming_enc_pipe.sv
// Self-checking bench for hamming_enc_pipe.
module tb_hamming_enc_pipe;

  localparam int W     = 32;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             clr = 1'b0;
  logic [1:0]       mode = '0;
  logic [W-1:0]     data_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     enc_out;
  logic [1:0]       out_mode;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] enc_count;

  hamming_enc_pipe #(.AMBA_WORD(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .mode      (mode),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enc_out   (enc_out),
    .out_mode  (out_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc_count (enc_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Build the codeword from the layout rules: data bit k goes to cw[n+1+k];
  // the low n bits hold the XOR of the H columns of all set data bits; cw[n]
  // makes the total number of ones even.
  function automatic logic [W-1:0] model_enc(input logic [1:0] m, input logic [W-1:0] d);
    int n, dw, syn, v;
    logic [W-1:0] cw;
    case (m)
      2'b00:   begin n = 3; dw = 4;  end
      2'b01:   begin n = 4; dw = 11; end
      default: begin n = 5; dw = 26; end
    endcase
    syn = 0;
    v   = 3;
    cw  = '0;
    for (int k = 0; k < dw; k++) begin
      while ((v & (v - 1)) == 0) v++;
      if (d[k]) begin
        syn ^= v;
        cw[n + 1 + k] = 1'b1;
      end
      v++;
    end
    cw = cw | W'(syn);
    cw[n] = ^cw;
    return cw;
  endfunction

  // Decoder-side view: XOR of the columns of every set codeword bit must be 0.
  function automatic int syndrome(input logic [1:0] m, input logic [W-1:0] cw);
    int n, dw, syn, v;
    case (m)
      2'b00:   begin n = 3; dw = 4;  end
      2'b01:   begin n = 4; dw = 11; end
      default: begin n = 5; dw = 26; end
    endcase
    syn = 0;
    for (int i = 0; i < n; i++) if (cw[i]) syn ^= (1 << i);
    v = 3;
    for (int k = 0; k < dw; k++) begin
      while ((v & (v - 1)) == 0) v++;
      if (cw[n + 1 + k]) syn ^= v;
      v++;
    end
    return syn;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+1:0]     exp_q[$];   // {mode, codeword}
  int               rdy_q[$];   // cycle from which the word must be on enc_out
  logic [CNT_W-1:0] exp_cnt = '0;
  int               cyc = 0;
  int               acc_cnt = 0;
  int               dlv_cnt = 0;

  always @(posedge clk) cyc++;

  // Single compare process: runs every negedge, where all DUT outputs and
  // bench inputs are stable for the coming rising edge.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    logic [W+1:0] front;
    if (!rst) begin
      check("rst_in_ready", W'(in_ready), '0);
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_enc_out", enc_out, '0);
      check("rst_out_mode", W'(out_mode), '0);
      check("rst_enc_count", W'(enc_count), '0);
      exp_q.delete();
      rdy_q.delete();
      exp_cnt = '0;
    end else begin
      exp_valid = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
      exp_ready = !((exp_q.size() == 2) && !out_ready);
      check("out_valid", W'(out_valid), W'(exp_valid));
      check("in_ready", W'(in_ready), W'(exp_ready));
      check("enc_count", W'(enc_count), W'(exp_cnt));
      if (out_valid && exp_q.size() > 0) begin
        front = exp_q[0];
        check("enc_out", enc_out, front[W-1:0]);
        check("out_mode", W'(out_mode), W'(front[W+1:W]));
      end
      if (clr) begin
        exp_q.delete();
        rdy_q.delete();
        exp_cnt = '0;
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
          exp_cnt = exp_cnt + CNT_W'(1);
          dlv_cnt++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back({mode, model_enc(mode, data_in)});
          rdy_q.push_back(cyc + 2);
          acc_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] m, input logic [W-1:0] d);
    bit done;
    done     = 0;
    mode     = m;
    data_in  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("drain", W'(done), W'(1));
  endtask

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int d0;
    logic [1:0] m;

    // Model pinned to hand-computed codewords.
    check("model_s1",  model_enc(2'b00, 32'h1),       32'h0000001B);
    check("model_sF",  model_enc(2'b00, 32'hF),       32'h000000FF);
    check("model_s0",  model_enc(2'b00, 32'h0),       32'h00000000);
    check("model_m0",  model_enc(2'b01, 32'h0),       32'h00000000);
    check("model_l0",  model_enc(2'b10, 32'h0),       32'h00000000);
    check("model_m1",  model_enc(2'b01, 32'h001),     32'h00000033);
    check("model_l1",  model_enc(2'b10, 32'h1),       32'h00000063);
    check("model_lhi", model_enc(2'b10, 32'h2000000), 32'h8000001F);
    check("model_m3",  model_enc(2'b11, 32'h1),       32'h00000063);
    for (int i = 0; i < 20; i++) begin
      m = 2'($urandom_range(0, 3));
      check("model_syn", W'(syndrome(m, model_enc(m, $urandom()))), '0);
    end

    // Reset phase.
    idle(3);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // Directed codewords, including ignored upper payload bits and mode 11.
    send(2'b00, 32'h1);
    send(2'b00, 32'hF);
    send(2'b00, 32'h0);
    send(2'b01, 32'h001);
    send(2'b10, 32'h1);
    send(2'b10, 32'h2000000);
    send(2'b11, 32'h1);
    send(2'b00, 32'hFFFF_FFF1);
    send(2'b01, 32'hFFFF_F800);
    send(2'b10, 32'h0);
    drain();

    // Back-to-back 8 words from a cleared counter.
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), $urandom());
    drain();
    check("b2b_count", W'(enc_count), 32'd8);

    // Stall: 5 cycles with out_ready low while a stream is offered.
    a0 = acc_cnt;
    d0 = dlv_cnt;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)), $urandom());
      begin
        repeat (5) @(posedge clk);
        check("stall_accepts", W'(acc_cnt - a0), 32'd2);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered", W'(dlv_cnt - d0), 32'd6);

    // Flush with both stages full and a word offered.
    out_ready = 1'b0;
    send(2'b01, $urandom());
    send(2'b10, $urandom());
    mode     = 2'b00;
    data_in  = 32'h5;
    in_valid = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", W'(out_valid), '0);
    check("clr_enc_count", W'(enc_count), '0);
    check("clr_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    idle(3);
    check("clr_no_accept", W'(out_valid), '0);

    // Randomized traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode    = 2'b10;
      data_in = $urandom();
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", W'(out_valid), '0);
    check("rst_mid_enc_out", enc_out, '0);
    check("rst_mid_count", W'(enc_count), '0);
    @(posedge clk);
    #1;
    send(2'b00, 32'h1);
    @(posedge clk);
    #1;
    check("fresh_valid", W'(out_valid), W'(1));
    check("fresh_enc_out", enc_out, 32'h0000001B);
    drain();
    check("queue_empty", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
